// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: range-checks a 32-bit immediate against its
// format and packs it into the instruction [31:7] field image, with counters.
module imm_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] imm_in,
    input  logic [2:0]  imm_src,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] imm_data,
    output logic        out_err,
    input  logic        cnt_clr,
    output logic [15:0] enc_count,
    output logic [15:0] err_count
);

    localparam logic [2:0] SRC_I   = 3'b000;
    localparam logic [2:0] SRC_S   = 3'b001;
    localparam logic [2:0] SRC_B   = 3'b010;
    localparam logic [2:0] SRC_LUI = 3'b011;
    localparam logic [2:0] SRC_JAL = 3'b100;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // True when imm fits the selected format; illegal selectors never fit.
    function automatic logic range_ok(input logic [31:0] imm, input logic [2:0] src);
        logic ok;
        ok = 1'b0;
        case (src)
            SRC_I, SRC_S: ok = (imm[31:11] == {21{imm[31]}});
            SRC_B:        ok = (imm[31:12] == {20{imm[31]}}) && (imm[0] == 1'b0);
            SRC_LUI:      ok = (imm[11:0] == 12'd0);
            SRC_JAL:      ok = (imm[31:21] == 11'd0) && (imm[0] == 1'b0);
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Scatter immediate bits into their instruction positions (bit n = instr bit n+7).
    function automatic logic [24:0] pack_field(input logic [31:0] imm, input logic [2:0] src);
        logic [24:0] f;
        f = 25'd0;
        case (src)
            SRC_I: begin
                f[24:13] = imm[11:0];
            end
            SRC_S: begin
                f[24:18] = imm[11:5];
                f[4:0]   = imm[4:0];
            end
            SRC_B: begin
                f[24]    = imm[12];
                f[23:18] = imm[10:5];
                f[4:1]   = imm[4:1];
                f[0]     = imm[11];
            end
            SRC_LUI: begin
                f[24:5]  = imm[31:12];
            end
            SRC_JAL: begin
                f[24]    = imm[20];
                f[23:14] = imm[10:1];
                f[13]    = imm[11];
                f[12:5]  = imm[19:12];
            end
            default: begin
                f = 25'd0;
            end
        endcase
        return f;
    endfunction

    logic        s1_valid_r;
    logic [31:0] s1_imm_r;
    logic [2:0]  s1_src_r;
    logic        s1_ok_r;

    logic        s2_valid_r;
    logic [24:0] s2_data_r;
    logic        s2_err_r;

    logic [15:0] enc_count_r;
    logic [15:0] err_count_r;

    logic        s1_adv_s;
    logic        s2_adv_s;
    logic        out_hs_s;
    logic [24:0] s2_data_nxt_s;
    logic        s2_err_nxt_s;

    // Pipeline advance control and stage-2 next values.
    always_comb begin
        s2_adv_s      = 1'b0;
        s1_adv_s      = 1'b0;
        out_hs_s      = 1'b0;
        s2_data_nxt_s = 25'd0;
        s2_err_nxt_s  = 1'b0;

        s2_adv_s = ~s2_valid_r | out_ready;
        s1_adv_s = ~s1_valid_r | s2_adv_s;
        out_hs_s = s2_valid_r & out_ready;

        // A rejected or empty slot carries an all-zero field image.
        if (s1_valid_r && s1_ok_r) begin
            s2_data_nxt_s = pack_field(s1_imm_r, s1_src_r);
        end else begin
            s2_data_nxt_s = 25'd0;
        end
        s2_err_nxt_s = s1_valid_r & ~s1_ok_r;
    end

    // Stage 1: capture the raw word and its range-check verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_imm_r   <= 32'd0;
            s1_src_r   <= 3'd0;
            s1_ok_r    <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            s1_imm_r   <= imm_in;
            s1_src_r   <= imm_src;
            s1_ok_r    <= range_ok(imm_in, imm_src);
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: packed result, held until the downstream handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= 25'd0;
            s2_err_r   <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            s2_data_r  <= s2_data_nxt_s;
            s2_err_r   <= s2_err_nxt_s;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Saturating transfer/error counters; clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_count_r <= 16'd0;
            err_count_r <= 16'd0;
        end else if (cnt_clr) begin
            enc_count_r <= 16'd0;
            err_count_r <= 16'd0;
        end else if (out_hs_s) begin
            if (enc_count_r != CNT_MAX) begin
                enc_count_r <= enc_count_r + 16'd1;
            end
            if (s2_err_r && (err_count_r != CNT_MAX)) begin
                err_count_r <= err_count_r + 16'd1;
            end
        end else begin
            enc_count_r <= enc_count_r;
        end
    end

    assign in_ready  = s1_adv_s;
    assign out_valid = s2_valid_r;
    assign imm_data  = s2_data_r;
    assign out_err   = s2_err_r;
    assign enc_count = enc_count_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: random and directed words are checked
// against an instruction-bit-level reference model.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] imm_in;
    logic [2:0]  imm_src;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] imm_data;
    logic        out_err;
    logic        cnt_clr;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    imm_encoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .imm_in(imm_in), .imm_src(imm_src),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm_data(imm_data), .out_err(out_err),
        .cnt_clr(cnt_clr), .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [24:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        popped;
    int          n_checks = 0;
    int          n_errors = 0;
    int          enc_m = 0;
    int          err_m = 0;
    int          cyc = 0;
    logic        stalled = 1'b0;
    logic [24:0] held_data;
    logic        held_err;
    logic [24:0] last_data = 25'd0;
    logic        last_err = 1'b0;
    logic        rand_bp = 1'b0;

    logic [31:0] dir_val [9] = '{32'hFFFFF800, 32'h00000800, 32'h00000FFE, 32'h00000FFF,
                                 32'h12345000, 32'h12345001, 32'h00100000, 32'h00200000,
                                 32'h00000000};
    logic [2:0]  dir_src [9] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5};
    logic [24:0] dir_data[9] = '{25'h1000000, 25'h0, 25'h0FC001F, 25'h0, 25'h02468A0, 25'h0,
                                 25'h1000000, 25'h0, 25'h0};
    logic        dir_err [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: decide representability by numeric range, then build the
    // instruction word the decoder would see and take bits [31:7].
    function automatic exp_t ref_model(input logic [31:0] v, input logic [2:0] s);
        exp_t        e;
        int signed   sv;
        logic        ok;
        logic [31:0] instr;
        sv    = $signed(v);
        instr = 32'd0;
        ok    = 1'b0;
        case (s)
            3'd0: begin
                ok = (sv >= -2048) && (sv <= 2047);
                instr[31:20] = v[11:0];
            end
            3'd1: begin
                ok = (sv >= -2048) && (sv <= 2047);
                instr[31:25] = v[11:5];
                instr[11:7]  = v[4:0];
            end
            3'd2: begin
                ok = (sv >= -4096) && (sv <= 4095) && (v % 2 == 0);
                instr[31]    = v[12];
                instr[30:25] = v[10:5];
                instr[11:8]  = v[4:1];
                instr[7]     = v[11];
            end
            3'd3: begin
                ok = (v % 4096 == 0);
                instr[31:12] = v[31:12];
            end
            3'd4: begin
                ok = (v < 32'h0020_0000) && (v % 2 == 0);
                instr[31]    = v[20];
                instr[30:21] = v[10:1];
                instr[20]    = v[11];
                instr[19:12] = v[19:12];
            end
            default: ok = 1'b0;
        endcase
        e.data = ok ? instr[31:7] : 25'd0;
        e.err  = ~ok;
        return e;
    endfunction

    function automatic logic [31:0] rand_val();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 4))
            0: v = v;
            1: v = $signed(v) >>> 20;
            2: v = $signed(v) >>> 19;
            3: v = v >> 11;
            default: v = v << 12;
        endcase
        if ($urandom_range(0, 1) == 1) v[0] = 1'b0;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance side: each accepted word pushes its expected result.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) exp_q.push_back(ref_model(imm_in, imm_src));
    end

    // Output side: pop/compare on handshakes, stall stability, counter model.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
            enc_m   = 0;
            err_m   = 0;
        end else begin
            check("enc_count", {16'd0, enc_count}, enc_m);
            check("err_count", {16'd0, err_count}, err_m);
            if (stalled) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", {7'd0, imm_data}, {7'd0, held_data});
                check("stall_err", {31'd0, out_err}, {31'd0, held_err});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got data 0x%0h err %0b, expected none", imm_data, out_err);
                end else begin
                    popped = exp_q.pop_front();
                    check("out_data", {7'd0, imm_data}, {7'd0, popped.data});
                    check("out_err", {31'd0, out_err}, {31'd0, popped.err});
                end
                last_data = imm_data;
                last_err  = out_err;
            end
            stalled   = out_valid && !out_ready;
            held_data = imm_data;
            held_err  = out_err;
            if (cnt_clr) begin
                enc_m = 0;
                err_m = 0;
            end else if (out_valid && out_ready) begin
                if (enc_m < 65535) enc_m++;
                if (out_err && err_m < 65535) err_m++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [31:0] v, input logic [2:0] s);
        int t;
        t = 0;
        in_valid = 1'b1;
        imm_in   = v;
        imm_src  = s;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            step();
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got in_ready 0, expected 1 within 100 cycles");
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            step();
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        int c0;
        rst = 1'b1; in_valid = 1'b0; imm_in = 32'd0; imm_src = 3'd0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_imm_data", {7'd0, imm_data}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_enc_count", {16'd0, enc_count}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            send(dir_val[i], dir_src[i]);
            drain();
            check($sformatf("dir_data_%0d", i), {7'd0, last_data}, {7'd0, dir_data[i]});
            check($sformatf("dir_err_%0d", i), {31'd0, last_err}, {31'd0, dir_err[i]});
        end

        // Latency from an empty pipeline.
        in_valid = 1'b1; imm_in = 32'h0000_0123; imm_src = 3'd0;
        @(negedge clk);
        check("lat_accept", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_n", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_n1", {31'd0, out_valid}, 32'd1);
        drain();

        // Eight back-to-back words at full rate.
        c0 = cyc;
        for (int i = 0; i < 8; i++) send(rand_val(), 3'($urandom_range(0, 4)));
        check("stream_cycles", cyc - c0, 32'd8);
        drain();

        // Backpressure: two slots fill, third word waits.
        out_ready = 1'b0;
        in_valid = 1'b1; imm_in = 32'h0000_0010; imm_src = 3'd0;
        @(negedge clk); check("bp_ready_w0", {31'd0, in_ready}, 32'd1);
        step(); imm_in = 32'h0000_2000; imm_src = 3'd3;
        @(negedge clk); check("bp_ready_w1", {31'd0, in_ready}, 32'd1);
        step(); imm_in = 32'h0000_0FFE; imm_src = 3'd2;
        @(negedge clk); check("bp_ready_w2", {31'd0, in_ready}, 32'd0);
        repeat (3) step();
        @(negedge clk); check("bp_hold", {31'd0, in_ready}, 32'd0);
        step();
        out_ready = 1'b1;
        #1 check("bp_release", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        step();
        in_valid = 1'b0;
        drain();

        // Counters: 4 transfers, 1 with error.
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        send(32'h0000_0001, 3'd0);
        send(32'h0000_0800, 3'd1);
        send(32'h0010_0000, 3'd4);
        send(32'hFFFF_F000, 3'd3);
        drain();
        check("cnt_enc4", {16'd0, enc_count}, 32'd4);
        check("cnt_err1", {16'd0, err_count}, 32'd1);

        // Clear coincident with a handshake.
        out_ready = 1'b0;
        send(32'h0000_0800, 3'd0);
        repeat (2) step();
        out_ready = 1'b1; cnt_clr = 1'b1;
        @(negedge clk);
        check("clr_hs_valid", {31'd0, out_valid}, 32'd1);
        step();
        cnt_clr = 1'b0;
        check("clr_enc0", {16'd0, enc_count}, 32'd0);
        check("clr_err0", {16'd0, err_count}, 32'd0);
        drain();

        // Randomized traffic with random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(rand_val(), 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) step();
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with two words in flight.
        out_ready = 1'b0;
        send(32'h0000_0005, 3'd0);
        send(32'h0000_0006, 3'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_data", {7'd0, imm_data}, 32'd0);
        check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_enc", {16'd0, enc_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Pipelined immediate encoder: the inverse of the core's immediate-extension stage. It takes a 32-bit immediate value plus an immediate-format selector, checks that the value is representable in that format, and packs it into the 25-bit instruction field image `imm_data` (instruction bits [31:7]). It sits in the program-loader/instruction-assembly path ahead of instruction memory. It uses valid/ready handshakes on both sides and keeps transfer and error statistics.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  an input word is present.
- `in_ready`  out  1  the encoder accepts the input word this cycle.
- `imm_in`  in  32  immediate value to encode.
- `imm_src`  in  3  format: 000 I, 001 S, 010 B, 011 LUI, 100 JAL; 101–111 are illegal.
- `out_valid`  out  1  an encoded result is present.
- `out_ready`  in  1  the downstream block accepts the result this cycle.
- `imm_data`  out  25  packed field image (bit n corresponds to instruction bit n+7).
- `out_err`  out  1  the value was not representable, or `imm_src` was illegal.
- `cnt_clr`  in  1  synchronous clear for both counters.
- `enc_count`  out  16  completed output transfers, saturating at 0xFFFF.
- `err_count`  out  16  completed output transfers with `out_err`=1, saturating at 0xFFFF.

## Operation
- Representability rules (`out_err`=1 when the rule is violated):
  - I, S: `imm_in[31:11]` all equal.
  - B: `imm_in[31:12]` all equal and `imm_in[0]`=0.
  - LUI: `imm_in[11:0]`=0.
  - JAL: `imm_in[31:21]`=0 and `imm_in[0]`=0. JAL is zero-extended, matching the decode side.
  - Illegal `imm_src` always sets `out_err`.
- Packing. Bits not listed are 0. On error, `imm_data` is forced to 0.
  - I: [24:13]=imm[11:0].
  - S: [24:18]=imm[11:5]; [4:0]=imm[4:0].
  - B: [24]=imm[12]; [23:18]=imm[10:5]; [4:1]=imm[4:1]; [0]=imm[11].
  - LUI: [24:5]=imm[31:12].
  - JAL: [24]=imm[20]; [23:14]=imm[10:1]; [13]=imm[11]; [12:5]=imm[19:12].
- Pipeline structure:
  - Stage 1 registers `imm_in`, `imm_src` and the range-check result.
  - Stage 2 registers the packed `imm_data` and `out_err`.
  - `imm_data`, `out_err` and `out_valid` are driven directly from stage-2 registers.
- Advance rules:
  - s2_adv = !s2_valid | `out_ready`.
  - s1_adv = !s1_valid | s2_adv.
  - `in_ready` = s1_adv (combinational from `out_ready`).
  - A stage holds its contents while it cannot advance.
  - Results leave in acceptance order; nothing is dropped or duplicated.
- Counters:
  - On each output handshake (`out_valid` & `out_ready`), `enc_count` increments.
  - On a handshake with `out_err`=1, `err_count` also increments.
  - Both counters saturate at 0xFFFF.
  - `cnt_clr` zeroes both counters next edge and wins over a simultaneous increment.
  - `cnt_clr` does not affect the pipeline.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `imm_data`=0, `out_err`=0, `enc_count`=0, `err_count`=0.
- Reset asserted mid-operation discards all in-flight words immediately, independent of `clk`.
- Latency: a word accepted at edge N appears with `out_valid`=1 after edge N+1, assuming no stall.
- Throughput: one word per cycle when `out_ready` is held high.
- Capacity: with `out_ready`=0, two words are accepted, then `in_ready` drops to 0.
  - Re-asserting `out_ready` raises `in_ready` in the same cycle.
  - In that cycle, an accept and an output transfer happen on the same edge.
- `out_valid` and the stage-2 data stay stable until the handshake completes.

## Test plan
- Format encoding, no stall:
  - I with `imm_in`=0xFFFFF800 -> `imm_data`=0x1000000, err 0.
  - I with `imm_in`=0x00000800 -> err 1, `imm_data`=0.
- B and LUI:
  - B 0x00000FFE -> 0xFC001F.
  - B 0x00000FFF -> err 1.
  - LUI 0x12345000 -> 0x2468A0.
  - LUI 0x12345001 -> err 1.
- JAL and illegal selector:
  - JAL 0x00100000 -> 0x1000000.
  - JAL 0x00200000 -> err 1.
  - `imm_src`=101 -> err 1.
- Back-to-back streaming:
  - 8 consecutive words with `out_ready`=1 -> first `out_valid` 2 edges after the first accept, then one result per cycle, in order.
- Backpressure:
  - `out_ready`=0 while 3 words are offered -> 2 accepted, `in_ready`=0 on the third.
  - Release `out_ready` -> all 3 emerge in order, with `imm_data` stable during the stall.
- Counters and reset:
  - 4 transfers, 1 erroneous -> `enc_count`=4, `err_count`=1.
  - `cnt_clr` asserted together with a handshake -> both counters 0.
  - `rst` pulsed with 2 words in flight -> `out_valid`=0 immediately, no stale output after release.
